// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//
// Bridges a cache's whole-line refill/writeback requests onto AXI read and write bursts.
// Only one transaction is outstanding at a time. A refill streams the R beats straight
// back to the cache with no added latency. A writeback replays a captured copy of the line.
//
// Build option: AXI_BRIDGE_WRITEBACK_EN
//   defined   - full AW/W/B writeback path with a captured line register.
//   undefined - write channel tied off. No line register is built. A writeback request
//               is acknowledged with wr_done on the cycle after acceptance.
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   req_valid/req_we/req_addr/req_wline cache line request (we=1 writeback, 0 refill)
//   req_ready                           high only while idle
//   ret_valid/ret_data/ret_last         refill words, ascending address order
//   wr_done                             one-cycle writeback completion pulse
//   ar*/r*                              AXI read address/data channels
//   aw*/w*/b*                           AXI write address/data/response channels
module cache_axi_bridge #(
    parameter int unsigned LINE_WORDS = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    input  logic                       req_we,
    input  logic [31:0]                req_addr,
    input  logic [LINE_WORDS*32-1:0]   req_wline,
    output logic                       req_ready,
    output logic                       ret_valid,
    output logic [31:0]                ret_data,
    output logic                       ret_last,
    output logic                       wr_done,
    output logic                       arvalid,
    input  logic                       arready,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    input  logic                       rvalid,
    output logic                       rready,
    input  logic [31:0]                rdata,
    input  logic                       rlast,
    output logic                       awvalid,
    input  logic                       awready,
    output logic [31:0]                awaddr,
    output logic [7:0]                 awlen,
    output logic                       wvalid,
    input  logic                       wready,
    output logic [31:0]                wdata,
    output logic                       wlast,
    input  logic                       bvalid,
    output logic                       bready
);
    localparam int unsigned OffW = $clog2(LINE_WORDS * 4);
    localparam int unsigned CntW = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB} state_e;

    state_e      state_q;
    logic        out_of_reset_q;
    logic [31:0] addr_q;
    logic [31:0] line_addr;

    assign line_addr = {req_addr[31:OffW], {OffW{1'b0}}};

    // req_ready stays low until the first clock edge after reset release.
    assign req_ready = out_of_reset_q && (state_q == StIdle);

    // Read side: address/len come from registers captured at acceptance, so they are
    // stable for the whole time arvalid is high.
    assign arvalid   = (state_q == StAr);
    assign araddr    = addr_q;
    assign arlen     = 8'(LINE_WORDS - 1);
    assign rready    = (state_q == StR);
    assign ret_valid = (state_q == StR) && rvalid;
    assign ret_last  = (state_q == StR) && rvalid && rlast;
    assign ret_data  = rdata;

`ifdef AXI_BRIDGE_WRITEBACK_EN
    logic [LINE_WORDS*32-1:0] line_q;
    logic [CntW-1:0]          cnt_q;
    logic                     cnt_last;
    logic                     unused_addr_bits;

    assign cnt_last = (cnt_q == CntW'(LINE_WORDS - 1));
    assign awvalid  = (state_q == StAw);
    assign awaddr   = addr_q;
    assign awlen    = 8'(LINE_WORDS - 1);
    assign wvalid   = (state_q == StW);
    assign wdata    = line_q[cnt_q*32 +: 32];
    assign wlast    = (state_q == StW) && cnt_last;
    assign bready   = (state_q == StB);
    assign wr_done  = (state_q == StB) && bvalid;

    assign unused_addr_bits = ^req_addr[OffW-1:0];
`else
    logic unused_inputs;

    assign awvalid = 1'b0;
    assign awaddr  = '0;
    assign awlen   = '0;
    assign wvalid  = 1'b0;
    assign wdata   = '0;
    assign wlast   = 1'b0;
    assign bready  = 1'b0;
    // StB doubles as the one-cycle acknowledge state for a writeback with no bus traffic.
    assign wr_done = (state_q == StB);

    assign unused_inputs = ^{req_addr[OffW-1:0], req_wline, awready, wready, bvalid};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            out_of_reset_q <= 1'b0;
            addr_q         <= '0;
`ifdef AXI_BRIDGE_WRITEBACK_EN
            line_q         <= '0;
            cnt_q          <= '0;
`endif
        end else begin
            out_of_reset_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (req_valid && req_ready) begin
                        addr_q <= line_addr;
                        if (req_we) begin
`ifdef AXI_BRIDGE_WRITEBACK_EN
                            line_q  <= req_wline;
                            cnt_q   <= '0;
                            state_q <= StAw;
`else
                            state_q <= StB;
`endif
                        end else begin
                            state_q <= StAr;
                        end
                    end
                end
                StAr: if (arready) state_q <= StR;
                // rlast ends the burst regardless of how many beats arrived.
                StR:  if (rvalid && rlast) state_q <= StIdle;
`ifdef AXI_BRIDGE_WRITEBACK_EN
                StAw: if (awready) state_q <= StW;
                StW: begin
                    if (wready) begin
                        if (cnt_last) begin
                            cnt_q   <= '0;
                            state_q <= StB;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StB:  if (bvalid) state_q <= StIdle;
`else
                StAw: state_q <= StIdle;
                StW:  state_q <= StIdle;
                StB:  state_q <= StIdle;
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 16: 32-bit words per cache line, a power of two, 2..256.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1: the cache presents a line request.
REQ-005 SHALL have port req_we, input, 1: 1 = writeback, 0 = refill.
REQ-006 SHALL have port req_addr, input, 32: byte address inside the target line.
REQ-007 SHALL have port req_wline, input, LINE_WORDS*32: writeback line; word 0 is in bits [31:0].
REQ-008 SHALL have port req_ready, output, 1: the bridge accepts a request this cycle.
REQ-009 SHALL have port ret_valid, output, 1: a refill word is on ret_data.
REQ-010 SHALL have port ret_data, output, 32: refill word, in ascending address order.
REQ-011 SHALL have port ret_last, output, 1: marks the final refill word.
REQ-012 SHALL have port wr_done, output, 1: one-cycle pulse when a writeback completes.
REQ-013 SHALL have AXI read ports: arvalid out 1, arready in 1, araddr out 32, arlen out 8, rvalid in 1, rready out 1, rdata in 32, rlast in 1.
REQ-014 SHALL have AXI write ports: awvalid out 1, awready in 1, awaddr out 32, awlen out 8, wvalid out 1, wready in 1, wdata out 32, wlast out 1, bvalid in 1, bready out 1.

Function
REQ-015 SHALL run a single-outstanding FSM with states IDLE, AR, R, AW, W, B.
- req_ready = 1 only in IDLE.
- On req_valid && req_ready, the FSM SHALL register req_addr and req_wline, then go to AR (req_we=0) or AW (req_we=1).
REQ-016 SHALL drive araddr/awaddr as the line-aligned address: req_addr with its low log2(LINE_WORDS*4) bits zeroed.
- arlen = awlen = LINE_WORDS-1.
- Size is 4 bytes and burst type is INCR; the interconnect implies both.
REQ-017 SHALL handle the AR/AW handshake:
- arvalid/awvalid is held high until the ready handshake, then goes low.
- On handshake: AR->R, AW->W.
- Address and len SHALL stay stable while valid is high.
REQ-018 SHALL handle the R state:
- rready = 1.
- Each rvalid cycle gives ret_valid=1 and ret_data=rdata in the same cycle (zero added latency).
- ret_last = rlast; the rlast beat returns the FSM to IDLE.
- rlast SHALL be obeyed even if the beat count differs from LINE_WORDS.
REQ-019 SHALL handle the W state:
- A beat counter 0..LINE_WORDS-1 selects wdata = word[counter].
- wvalid = 1; the counter advances on wvalid && wready.
- wlast = 1 when counter = LINE_WORDS-1; that beat's handshake moves the FSM to B.
REQ-020 SHALL handle the B state:
- bready = 1.
- On bvalid: wr_done=1 for one cycle and return to IDLE.
- bresp is ignored.
REQ-021 SHALL accept a new request no earlier than the cycle after returning to IDLE; back-to-back requests therefore have a 1-cycle IDLE gap.
REQ-022 SHALL keep outputs low when idle: ret_valid, ret_last and wr_done SHALL be 0 whenever their state conditions are not met.

Reset
REQ-023 SHALL, with rst_n=0 (asynchronous), go to IDLE, clear the counter, and force these outputs to 0: arvalid, awvalid, wvalid, rready, bready, ret_valid, ret_last, wr_done. req_ready becomes 1 from the first clock after release.
REQ-024 SHALL, on reset mid-burst, abandon the transaction with no completion pulse.

Configuration
REQ-025 SHALL, with AXI_BRIDGE_WRITEBACK_EN defined, implement the AW/W/B path as specified above.
REQ-026 SHALL, with AXI_BRIDGE_WRITEBACK_EN undefined:
- awvalid, wvalid, wlast and bready are tied 0; awaddr, awlen and wdata are tied 0.
- No line register is built.
- An accepted req_we=1 request produces wr_done=1 on the next cycle and returns to IDLE with no bus activity.

Verification
REQ-027 SHALL cover refill: req_addr=0x8000_0044, arready after 2 cycles -> araddr=0x8000_0040, arlen=15; 16 rdata beats 0..15 appear on ret_data same cycle; ret_last only with beat 15.
REQ-028 SHALL cover writeback with backpressure: req_we=1, word i = i+0x100, wready toggling every cycle -> 16 beats in order, wlast only on 0x10F; bvalid gives wr_done for exactly 1 cycle.
REQ-029 SHALL cover a short burst: rlast asserted on beat 3 -> ret_last on beat 3, FSM in IDLE; req_ready=1 on the next cycle.
REQ-030 SHALL cover reset mid-burst: rst_n low during W beat 5 -> all valids 0 immediately, no wr_done; a new refill then completes normally.
REQ-031 SHALL cover the macro undefined: req_we=1 accepted -> wr_done pulses on the next cycle; awvalid/wvalid stay 0 throughout.
